// File: rtl/apb_req_arbiter.sv
// -----------------------------------------------------------------------------
// apb_req_arbiter
//
// Round-robin arbiter and APB transfer sequencer for the 8-bit APB link.
// NUM_REQ local requesters compete for the single APB port. The winner's
// command is latched onto the APB outputs. The block then runs the SETUP and
// ACCESS phases and waits for the slave's ready. Finally it returns read data
// with a one-cycle done pulse to the owner.
//
// Optional build macro:
//   APB_TIMEOUT_EN - ACCESS gives up after TIMEOUT cycles without ready and
//                    answers the owner with an err pulse instead of done.
//                    When undefined, ACCESS waits forever and err stays 0.
//
// Parameters:
//   NUM_REQ  number of requesters (2..8)
//   TIMEOUT  ACCESS-phase cycle limit (only with APB_TIMEOUT_EN)
//
// Ports:
//   clk              system clock, all logic on the rising edge
//   reset            synchronous active-high reset
//   req              per-requester transfer request, held until done
//   req_write        per-requester direction, 1 = write
//   req_addr         per-requester address, requester i in [8i+7:8i]
//   req_wdata        per-requester write data
//   req_wait         per-requester wait_cycles value for the slave
//   grant            one-hot owner of the current transfer
//   done             one-cycle completion pulse to the owner
//   err              one-cycle timeout pulse to the owner
//   rdata_out        read data, valid while done is high
//   busy             high whenever the sequencer is not idle
//   apb_sel          APB select
//   apb_enable       APB enable
//   apb_write        APB direction
//   apb_addr         APB address
//   apb_wdata        APB write data
//   apb_wait_cycles  wait_cycles forwarded to the slave
//   apb_ready        slave ready
//   apb_rdata        slave read data
// -----------------------------------------------------------------------------
module apb_req_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     req_write,
    input  logic [8*NUM_REQ-1:0]   req_addr,
    input  logic [8*NUM_REQ-1:0]   req_wdata,
    input  logic [8*NUM_REQ-1:0]   req_wait,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     done,
    output logic [NUM_REQ-1:0]     err,
    output logic [7:0]             rdata_out,
    output logic                   busy,
    output logic                   apb_sel,
    output logic                   apb_enable,
    output logic                   apb_write,
    output logic [7:0]             apb_addr,
    output logic [7:0]             apb_wdata,
    output logic [7:0]             apb_wait_cycles,
    input  logic                   apb_ready,
    input  logic [7:0]             apb_rdata
);

    localparam int               PTR_W     = $clog2(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);
    localparam logic [PTR_W:0]   NUM_REQ_C = (PTR_W + 1)'(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Registered state and outputs
    state_t              state_r;
    logic [PTR_W-1:0]    ptr_r;
    logic [NUM_REQ-1:0]  grant_r;
    logic [NUM_REQ-1:0]  done_r;
    logic [NUM_REQ-1:0]  err_r;
    logic                busy_r;
    logic                sel_r;
    logic                enable_r;
    logic                write_r;
    logic [7:0]          addr_r;
    logic [7:0]          wdata_r;
    logic [7:0]          wait_r;
    logic [7:0]          rdata_r;

    // Next-state values
    state_t              state_nxt_s;
    logic [PTR_W-1:0]    ptr_nxt_s;
    logic [NUM_REQ-1:0]  grant_nxt_s;
    logic [NUM_REQ-1:0]  done_nxt_s;
    logic [NUM_REQ-1:0]  err_nxt_s;
    logic                busy_nxt_s;
    logic                sel_nxt_s;
    logic                enable_nxt_s;
    logic                write_nxt_s;
    logic [7:0]          addr_nxt_s;
    logic [7:0]          wdata_nxt_s;
    logic [7:0]          wait_nxt_s;
    logic [7:0]          rdata_nxt_s;

    // Round-robin pick
    logic [2*NUM_REQ-1:0] req_dbl_s;
    logic [NUM_REQ-1:0]   req_rot_s;
    logic                 pick_valid_s;
    logic [PTR_W-1:0]     pick_off_s;
    logic [PTR_W:0]       pick_sum_s;
    logic [PTR_W-1:0]     pick_idx_s;

    // Command fields of the picked requester
    logic [NUM_REQ-1:0]   pick_grant_s;
    logic                 pick_write_s;
    logic [7:0]           pick_addr_s;
    logic [7:0]           pick_wdata_s;
    logic [7:0]           pick_wait_s;

`ifdef APB_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    logic [7:0]           cnt_r;
    logic [7:0]           cnt_nxt_s;
`else
    // TIMEOUT only matters when the timeout feature is built in
    logic [7:0]           timeout_unused_s;
    assign timeout_unused_s = 8'(TIMEOUT);
`endif

    // Rotate the request vector so the pointer position lands on bit 0, then
    // take the lowest set bit; offset plus pointer (mod NUM_REQ) is the winner.
    always_comb begin
        req_dbl_s    = {req, req};
        req_rot_s    = NUM_REQ'(req_dbl_s >> ptr_r);
        pick_valid_s = 1'b0;
        pick_off_s   = '0;
        // Scan downward so the nearest requester overwrites farther ones
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_rot_s[i]) begin
                pick_valid_s = 1'b1;
                pick_off_s   = PTR_W'(i);
            end else begin
                // no request at this offset; keep the nearer candidate
            end
        end
        pick_sum_s = {1'b0, ptr_r} + {1'b0, pick_off_s};
        if (pick_sum_s >= NUM_REQ_C) begin
            pick_idx_s = PTR_W'(pick_sum_s - NUM_REQ_C);
        end else begin
            pick_idx_s = pick_sum_s[PTR_W-1:0];
        end
    end

    // Multiplex the picked requester's command fields and build its grant
    always_comb begin
        pick_grant_s = '0;
        pick_write_s = 1'b0;
        pick_addr_s  = 8'h00;
        pick_wdata_s = 8'h00;
        pick_wait_s  = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx_s == PTR_W'(i)) begin
                pick_grant_s[i] = 1'b1;
                pick_write_s    = req_write[i];
                pick_addr_s     = req_addr[8*i +: 8];
                pick_wdata_s    = req_wdata[8*i +: 8];
                pick_wait_s     = req_wait[8*i +: 8];
            end else begin
                // not the winner
            end
        end
    end

    // Next-state and next-output logic; every register holds by default
    always_comb begin
        state_nxt_s  = state_r;
        ptr_nxt_s    = ptr_r;
        grant_nxt_s  = grant_r;
        done_nxt_s   = '0;
        err_nxt_s    = '0;
        sel_nxt_s    = sel_r;
        enable_nxt_s = enable_r;
        write_nxt_s  = write_r;
        addr_nxt_s   = addr_r;
        wdata_nxt_s  = wdata_r;
        wait_nxt_s   = wait_r;
        rdata_nxt_s  = rdata_r;
`ifdef APB_TIMEOUT_EN
        cnt_nxt_s    = cnt_r;
`endif

        case (state_r)
            ST_IDLE: begin
                sel_nxt_s    = 1'b0;
                enable_nxt_s = 1'b0;
                if (pick_valid_s) begin
                    // Latch the winner's command; it is frozen from here on
                    state_nxt_s = ST_SETUP;
                    grant_nxt_s = pick_grant_s;
                    write_nxt_s = pick_write_s;
                    addr_nxt_s  = pick_addr_s;
                    wdata_nxt_s = pick_wdata_s;
                    wait_nxt_s  = pick_wait_s;
                    sel_nxt_s   = 1'b1;
                    if (pick_idx_s == LAST_IDX) begin
                        ptr_nxt_s = '0;
                    end else begin
                        ptr_nxt_s = pick_idx_s + PTR_W'(1);
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                    grant_nxt_s = '0;
                end
            end

            ST_SETUP: begin
                state_nxt_s  = ST_ACCESS;
                sel_nxt_s    = 1'b1;
                enable_nxt_s = 1'b1;
`ifdef APB_TIMEOUT_EN
                cnt_nxt_s    = 8'h00;
`endif
            end

            ST_ACCESS: begin
                if (apb_ready) begin
                    state_nxt_s  = ST_DONE;
                    sel_nxt_s    = 1'b0;
                    enable_nxt_s = 1'b0;
                    done_nxt_s   = grant_r;
                    // Writes leave the previous read data in place
                    if (!write_r) begin
                        rdata_nxt_s = apb_rdata;
                    end else begin
                        rdata_nxt_s = rdata_r;
                    end
                end else begin
`ifdef APB_TIMEOUT_EN
                    // Ready on the limiting edge is handled above and wins
                    if ((cnt_r + 8'd1) == TIMEOUT_C) begin
                        state_nxt_s  = ST_DONE;
                        sel_nxt_s    = 1'b0;
                        enable_nxt_s = 1'b0;
                        err_nxt_s    = grant_r;
                        rdata_nxt_s  = 8'h00;
                    end else begin
                        cnt_nxt_s    = cnt_r + 8'd1;
                    end
`else
                    state_nxt_s = ST_ACCESS;
`endif
                end
            end

            ST_DONE: begin
                state_nxt_s  = ST_IDLE;
                grant_nxt_s  = '0;
                sel_nxt_s    = 1'b0;
                enable_nxt_s = 1'b0;
            end

            default: begin
                state_nxt_s  = ST_IDLE;
                grant_nxt_s  = '0;
                sel_nxt_s    = 1'b0;
                enable_nxt_s = 1'b0;
            end
        endcase

        busy_nxt_s = (state_nxt_s != ST_IDLE);
    end

    // State register, round-robin pointer and all registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            ptr_r    <= '0;
            grant_r  <= '0;
            done_r   <= '0;
            err_r    <= '0;
            busy_r   <= 1'b0;
            sel_r    <= 1'b0;
            enable_r <= 1'b0;
            write_r  <= 1'b0;
            addr_r   <= 8'h00;
            wdata_r  <= 8'h00;
            wait_r   <= 8'h00;
            rdata_r  <= 8'h00;
`ifdef APB_TIMEOUT_EN
            cnt_r    <= 8'h00;
`endif
        end else begin
            state_r  <= state_nxt_s;
            ptr_r    <= ptr_nxt_s;
            grant_r  <= grant_nxt_s;
            done_r   <= done_nxt_s;
            err_r    <= err_nxt_s;
            busy_r   <= busy_nxt_s;
            sel_r    <= sel_nxt_s;
            enable_r <= enable_nxt_s;
            write_r  <= write_nxt_s;
            addr_r   <= addr_nxt_s;
            wdata_r  <= wdata_nxt_s;
            wait_r   <= wait_nxt_s;
            rdata_r  <= rdata_nxt_s;
`ifdef APB_TIMEOUT_EN
            cnt_r    <= cnt_nxt_s;
`endif
        end
    end

    assign grant           = grant_r;
    assign done            = done_r;
    assign err             = err_r;
    assign busy            = busy_r;
    assign apb_sel         = sel_r;
    assign apb_enable      = enable_r;
    assign apb_write       = write_r;
    assign apb_addr        = addr_r;
    assign apb_wdata       = wdata_r;
    assign apb_wait_cycles = wait_r;
    assign rdata_out       = rdata_r;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_apb_req_arbiter
//
// Directed bench for apb_req_arbiter with NUM_REQ = 2 and TIMEOUT = 16.
// Inputs are driven and outputs are checked on the falling clock edge.
// The slave side is played by hand from the stimulus sequence.
// -----------------------------------------------------------------------------
module tb_apb_req_arbiter;

    localparam int N = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N-1:0]   req_write;
    logic [8*N-1:0] req_addr;
    logic [8*N-1:0] req_wdata;
    logic [8*N-1:0] req_wait;
    logic [N-1:0]   grant;
    logic [N-1:0]   done;
    logic [N-1:0]   err;
    logic [7:0]     rdata_out;
    logic           busy;
    logic           apb_sel;
    logic           apb_enable;
    logic           apb_write;
    logic [7:0]     apb_addr;
    logic [7:0]     apb_wdata;
    logic [7:0]     apb_wait_cycles;
    logic           apb_ready;
    logic [7:0]     apb_rdata;

    int n_total = 0;
    int n_bad   = 0;

    apb_req_arbiter #(
        .NUM_REQ (N),
        .TIMEOUT (16)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req             (req),
        .req_write       (req_write),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .req_wait        (req_wait),
        .grant           (grant),
        .done            (done),
        .err             (err),
        .rdata_out       (rdata_out),
        .busy            (busy),
        .apb_sel         (apb_sel),
        .apb_enable      (apb_enable),
        .apb_write       (apb_write),
        .apb_addr        (apb_addr),
        .apb_wdata       (apb_wdata),
        .apb_wait_cycles (apb_wait_cycles),
        .apb_ready       (apb_ready),
        .apb_rdata       (apb_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bus phase check: sel, enable, grant, done, busy in one call
    task automatic chk_bus(input string tag, input logic s, input logic e,
                           input logic [N-1:0] g, input logic [N-1:0] d, input logic b);
        chk({tag, ".sel"},    32'(apb_sel),    32'(s));
        chk({tag, ".enable"}, 32'(apb_enable), 32'(e));
        chk({tag, ".grant"},  32'(grant),      32'(g));
        chk({tag, ".done"},   32'(done),       32'(d));
        chk({tag, ".busy"},   32'(busy),       32'(b));
    endtask

    // Hard stop if the sequence ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        req       = 2'b00;
        req_write = 2'b00;
        req_addr  = 16'h0000;
        req_wdata = 16'h0000;
        req_wait  = 16'h0000;
        apb_ready = 1'b0;
        apb_rdata = 8'h00;
        tick();
        tick();

        // ---- reset state ----
        chk_bus("rst", 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        chk("rst.err",   32'(err),             32'h0);
        chk("rst.write", 32'(apb_write),       32'h0);
        chk("rst.addr",  32'(apb_addr),        32'h0);
        chk("rst.wdata", 32'(apb_wdata),       32'h0);
        chk("rst.wait",  32'(apb_wait_cycles), 32'h0);
        chk("rst.rdata", 32'(rdata_out),       32'h0);
        reset = 1'b0;

        // ---- req 0 write 0x10 <= 0xA5, wait 0 ----
        req_write[0]     = 1'b1;
        req_addr[7:0]    = 8'h10;
        req_wdata[7:0]   = 8'hA5;
        req_wait[7:0]    = 8'h00;
        req              = 2'b01;
        tick();
        chk_bus("wr.setup", 1'b1, 1'b0, 2'b01, 2'b00, 1'b1);
        chk("wr.setup.write", 32'(apb_write),       32'h1);
        chk("wr.setup.addr",  32'(apb_addr),        32'h10);
        chk("wr.setup.wdata", 32'(apb_wdata),       32'hA5);
        chk("wr.setup.wait",  32'(apb_wait_cycles), 32'h0);
        tick();
        chk_bus("wr.access", 1'b1, 1'b1, 2'b01, 2'b00, 1'b1);
        chk("wr.access.write", 32'(apb_write), 32'h1);
        apb_ready = 1'b1;
        tick();
        chk_bus("wr.done", 1'b0, 1'b0, 2'b01, 2'b01, 1'b1);
        chk("wr.done.write", 32'(apb_write), 32'h1);
        chk("wr.done.rdata", 32'(rdata_out), 32'h0);
        req       = 2'b00;
        apb_ready = 1'b0;
        tick();
        chk_bus("wr.idle", 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);

        // ---- req 1 read 0x10, wait 3 ----
        req_write[1]   = 1'b0;
        req_addr[15:8] = 8'h10;
        req_wait[15:8] = 8'h03;
        req            = 2'b10;
        tick();
        chk_bus("rd.setup", 1'b1, 1'b0, 2'b10, 2'b00, 1'b1);
        chk("rd.setup.write", 32'(apb_write),       32'h0);
        chk("rd.setup.wait",  32'(apb_wait_cycles), 32'h3);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_bus("rd.access", 1'b1, 1'b1, 2'b10, 2'b00, 1'b1);
        end
        apb_ready = 1'b1;
        apb_rdata = 8'hA5;
        tick();
        chk_bus("rd.done", 1'b0, 1'b0, 2'b10, 2'b10, 1'b1);
        chk("rd.done.rdata", 32'(rdata_out), 32'hA5);
        req       = 2'b00;
        apb_ready = 1'b0;
        apb_rdata = 8'h00;
        tick();
        chk_bus("rd.idle", 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        chk("rd.idle.rdata", 32'(rdata_out), 32'hA5);

`ifdef APB_TIMEOUT_EN
        // ---- slave never ready: err after 16 ACCESS cycles ----
        req = 2'b01;
        tick();
        chk_bus("to.setup", 1'b1, 1'b0, 2'b01, 2'b00, 1'b1);
        for (int i = 0; i < 16; i++) begin
            tick();
            chk_bus("to.access", 1'b1, 1'b1, 2'b01, 2'b00, 1'b1);
            chk("to.access.err", 32'(err), 32'h0);
        end
        tick();
        chk_bus("to.end", 1'b0, 1'b0, 2'b01, 2'b00, 1'b1);
        chk("to.end.err",   32'(err),       32'h1);
        chk("to.end.rdata", 32'(rdata_out), 32'h0);
        req = 2'b00;
        tick();
        chk_bus("to.idle", 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        chk("to.idle.err", 32'(err), 32'h0);
`endif

        // ---- both requesting continuously after reset: strict alternation ----
        reset = 1'b1;
        tick();
        reset          = 1'b0;
        req_write      = 2'b11;
        req_addr[7:0]  = 8'h20;
        req_addr[15:8] = 8'h31;
        apb_ready      = 1'b1;
        req            = 2'b11;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_bus("rr.setup", 1'b1, 1'b0, (k % 2 == 0) ? 2'b01 : 2'b10, 2'b00, 1'b1);
            chk("rr.setup.addr", 32'(apb_addr), (k % 2 == 0) ? 32'h20 : 32'h31);
            tick();
            chk_bus("rr.access", 1'b1, 1'b1, (k % 2 == 0) ? 2'b01 : 2'b10, 2'b00, 1'b1);
            tick();
            chk_bus("rr.done", 1'b0, 1'b0, (k % 2 == 0) ? 2'b01 : 2'b10,
                    (k % 2 == 0) ? 2'b01 : 2'b10, 1'b1);
            tick();
            chk_bus("rr.idle", 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        end
        req       = 2'b00;
        apb_ready = 1'b0;
        tick();

        // ---- reset in ACCESS aborts; pointer back to 0 ----
        req = 2'b01;
        tick();
        chk_bus("ra.setup", 1'b1, 1'b0, 2'b01, 2'b00, 1'b1);
        tick();
        chk_bus("ra.access", 1'b1, 1'b1, 2'b01, 2'b00, 1'b1);
        reset = 1'b1;
        tick();
        chk_bus("ra.reset", 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        chk("ra.reset.err", 32'(err), 32'h0);
        reset = 1'b0;
        // ready held high early: it must be ignored until ACCESS
        apb_ready = 1'b1;
        req       = 2'b11;
        tick();
        chk_bus("ra.contend", 1'b1, 1'b0, 2'b01, 2'b00, 1'b1);
        tick();
        chk_bus("ra.access2", 1'b1, 1'b1, 2'b01, 2'b00, 1'b1);
        tick();
        chk_bus("ra.done", 1'b0, 1'b0, 2'b01, 2'b01, 1'b1);
        req       = 2'b00;
        apb_ready = 1'b0;
        tick();
        chk_bus("ra.idle", 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);

        // ---- req dropped mid-transfer still completes, no retransfer ----
        req_addr[15:8] = 8'h44;
        req            = 2'b10;
        tick();
        chk_bus("dr.setup", 1'b1, 1'b0, 2'b10, 2'b00, 1'b1);
        chk("dr.setup.addr", 32'(apb_addr), 32'h44);
        tick();
        req            = 2'b00;
        req_addr[15:8] = 8'h99;
        tick();
        chk_bus("dr.access", 1'b1, 1'b1, 2'b10, 2'b00, 1'b1);
        chk("dr.access.addr", 32'(apb_addr), 32'h44);
        apb_ready = 1'b1;
        tick();
        chk_bus("dr.done", 1'b0, 1'b0, 2'b10, 2'b10, 1'b1);
        apb_ready = 1'b0;
        tick();
        chk_bus("dr.idle", 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        tick();
        chk_bus("dr.idle2", 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
- Round-robin arbiter and APB transfer sequencer for the 8-bit APB link.
- Accepts transfer requests from NUM_REQ local requesters (processor, I2C engine, DMA, ...) and grants the single APB port to one at a time.
- Drives the SETUP/ACCESS phases toward the APB slave, waits for ready, and returns read data plus a completion pulse to the granted requester.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT, 16, ACCESS-phase cycle limit; used only with APB_TIMEOUT_EN.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester transfer request; held high until done.
- req_write  input  NUM_REQ  per-requester direction, 1 = write.
- req_addr  input  8*NUM_REQ  per-requester address, requester i in bits [8i+7:8i].
- req_wdata  input  8*NUM_REQ  per-requester write data.
- req_wait  input  8*NUM_REQ  per-requester wait_cycles value forwarded to the slave.
- grant  output  NUM_REQ  one-hot owner of the current transfer.
- done  output  NUM_REQ  one-cycle completion pulse to the owner.
- err  output  NUM_REQ  one-cycle timeout pulse to the owner.
- rdata_out  output  8  read data; valid while done is high.
- busy  output  1  high in any state other than IDLE.
- apb_sel  output  1  APB select.
- apb_enable  output  1  APB enable.
- apb_write  output  1  APB direction.
- apb_addr  output  8  APB address.
- apb_wdata  output  8  APB write data.
- apb_wait_cycles  output  8  wait_cycles forwarded to the slave.
- apb_ready  input  1  slave ready.
- apb_rdata  input  8  slave read data.

Behaviour:
- States: IDLE, SETUP, ACCESS, DONE. All outputs are registered.
- Reset:
  - State goes to IDLE and the round-robin pointer to 0.
  - grant, done, err, busy, apb_sel, apb_enable and apb_write go to 0.
  - apb_addr, apb_wdata, apb_wait_cycles and rdata_out go to 8'h00.
  - Reset during any state aborts the transfer; no done or err pulse is issued.
- IDLE:
  - apb_sel = 0, apb_enable = 0.
  - If any req bit is high, select the first requester with req high, searching from pointer upward with wrap at NUM_REQ.
  - Latch that requester's write, addr, wdata and wait onto the apb_* outputs, set its grant bit, set pointer = (g+1) mod NUM_REQ, and go to SETUP.
  - If no req bit is high, stay in IDLE.
- SETUP:
  - Exactly one cycle with apb_sel = 1, apb_enable = 0; then go to ACCESS.
- ACCESS:
  - apb_sel = 1, apb_enable = 1; address, data and direction held stable.
  - Stay until apb_ready = 1 is sampled.
  - On that edge, capture apb_rdata into rdata_out (reads only; writes leave rdata_out unchanged) and go to DONE.
- DONE:
  - One cycle. apb_sel = 0, apb_enable = 0.
  - done[g] = 1, and grant stays asserted for this cycle.
  - Next state is IDLE, with grant cleared.
- Handshake:
  - The requester must drop req in the cycle it sees done.
  - A req still high in the following IDLE cycle starts a new transfer.
  - req deasserted mid-transfer is ignored; the transfer completes.
  - Changes to a requester's addr/wdata after grant have no effect.
- Latency: req sampled in IDLE at edge k gives SETUP at cycle k+1 and ACCESS from k+2. done comes one cycle after ready is sampled. Minimum transfer is 4 cycles (IDLE→DONE) and back-to-back transfers are 4 cycles apart.
- Simultaneous requests: served strictly round-robin. With all requesters asserting continuously, each is granted once per NUM_REQ transfers.
- apb_ready outside ACCESS is ignored.
- busy = (state != IDLE).

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to ACCESS and increments each ACCESS cycle without ready.
  - If it reaches TIMEOUT, go to DONE with err[g] = 1 and done[g] = 0, and set rdata_out = 8'h00.
  - The slave is then deselected as in normal DONE.
  - Ready arriving on the same edge the count reaches TIMEOUT wins, and completes normally.
- Not defined: ACCESS waits indefinitely and err is tied to 0.

Test Plan:
- Req 0 writes addr 8'h10, wdata 8'hA5, wait 0 → SETUP for 1 cycle with sel=1/enable=0, then ACCESS; slave ready → done[0] pulses once, apb_write=1 throughout, grant=2'b01.
- Req 1 reads addr 8'h10, wait 3 → apb_enable held until ready; rdata_out = 8'hA5 while done[1]=1; apb_wait_cycles = 3.
- req = 2'b11 held continuously after reset → grant order 01, 10, 01, 10; each transfer 4+ cycles apart; no requester served twice in a row.
- reset asserted during ACCESS → next cycle state IDLE, sel=0, enable=0, grant=0, no done; pointer = 0 so req 0 wins the next contention.
- APB_TIMEOUT_EN, TIMEOUT=16, slave never ready → err[g] pulses after 16 ACCESS cycles, done stays 0, rdata_out = 8'h00, then IDLE.
- Requester drops req during ACCESS → transfer still completes, done pulses, no retransfer follows.
